sd_cmd_engine: RTL and testbench

Hardware sequencer for the SD-card CMD line, replacing software bit-banging of the single-bit bidirectional command PIO. It generates SD_CLK, serializes a 48-bit command frame with CRC7, releases the line, waits for and captures a 48- or 136-bit response, checks its CRC7 and flags completion. It sits on the Avalon-MM system bus as a slave beside the SD data-line PIO, and drives the card's CMD pin and clock pin directly.

---
 rtl/sd_cmd_engine.sv | 203 ++++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_engine.sv
// SD-card CMD-line sequencer: Avalon-MM registers, SD_CLK divider, 48-bit command
// serializer with CRC7, 48/136-bit response capture and optional response CRC check.
module sd_cmd_engine #(
  parameter int CLK_DIV      = 4,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sd_clk,
  inout  wire         sd_cmd,
  output logic        irq
);
  localparam int            DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [15:0]   TO_LAST  = 16'(RESP_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic             sd_clk_q, sd_clk_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [47:0]      tx_q, tx_d;
  logic [126:0]     rx_q, rx_d;
  logic             oe_q, oe_d, out_q, out_d;
  logic [31:0]      arg_q, arg_d;
  logic [5:0]       idx_q, idx_d;
  logic [1:0]       rtype_q, rtype_d;
  logic             crc_en_q, crc_en_d;
  logic [3:0][31:0] resp_q, resp_d;
  logic             done_q, done_d, tout_q, tout_d, crc_err_q, crc_err_d;
  logic             ie_q, ie_d, irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             wr, rise, fall, busy;
  logic [127:0]     rx_next;
  logic [39:0]      hdr;
  logic [6:0]       rx_crc;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  assign wr      = chipselect & ~write_n;
  assign busy    = (state_q != S_IDLE);
  assign hdr     = {2'b01, writedata[5:0], arg_q};
  assign rx_next = {rx_q, sd_cmd};
  assign rx_crc  = crc7(rx_next[47:8]);

  always_comb begin
    state_d   = state_q;   div_d    = div_q;    sd_clk_d = sd_clk_q;
    cnt_d     = cnt_q;     tx_d     = tx_q;     rx_d     = rx_q;
    oe_d      = oe_q;      out_d    = out_q;    arg_d    = arg_q;
    idx_d     = idx_q;     rtype_d  = rtype_q;  crc_en_d = crc_en_q;
    resp_d    = resp_q;    done_d   = done_q;   tout_d   = tout_q;
    crc_err_d = crc_err_q; ie_d     = ie_q;
    rise      = 1'b0;      fall     = 1'b0;

    if (busy) begin
      if (div_q == DIV_LAST) begin
        div_d    = '0;
        sd_clk_d = ~sd_clk_q;
        rise     = ~sd_clk_q;
        fall     = sd_clk_q;
      end else begin
        div_d = div_q + DW'(1);
      end
    end

    if (wr) begin
      case (address)
        3'd0: arg_d = writedata;
        3'd2: begin
          ie_d = writedata[4];
          if (writedata[1]) begin
            done_d = 1'b0; tout_d = 1'b0; crc_err_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (wr && address == 3'd1 && !busy) begin
      state_d   = S_SEND;
      div_d     = '0;
      sd_clk_d  = 1'b0;
      cnt_d     = '0;
      tx_d      = {hdr, crc7(hdr), 1'b1};
      rx_d      = '0;
      idx_d     = writedata[5:0];
      rtype_d   = (writedata[9:8] == 2'd3) ? 2'd1 : writedata[9:8];
      crc_en_d  = writedata[10];
      resp_d    = '0;
      done_d    = 1'b0; tout_d = 1'b0; crc_err_d = 1'b0;
    end

    // The line only changes on falls; the card samples on rises.
    case (state_q)
      S_SEND: if (fall) begin
        if (cnt_q == 16'd48) begin
          oe_d    = 1'b0;
          cnt_d   = '0;
          state_d = (rtype_q == 2'd0) ? S_GAP : S_WAIT;
        end else begin
          oe_d  = 1'b1;
          out_d = tx_q[47];
          tx_d  = {tx_q[46:0], 1'b0};
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT: if (rise) begin
        if (!sd_cmd) begin
          rx_d    = rx_next[126:0];
          cnt_d   = 16'd1;
          state_d = S_RECV;
        end else if (cnt_q == TO_LAST) begin
          tout_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RECV: if (rise) begin
        rx_d  = rx_next[126:0];
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == ((rtype_q == 2'd2) ? 16'd135 : 16'd47)) begin
          cnt_d   = '0;
          state_d = S_GAP;
          if (rtype_q == 2'd2) begin
            resp_d = rx_next;
          end else begin
            resp_d[0] = rx_next[39:8];
            resp_d[1] = {17'b0, rx_next[7:1], 2'b0, rx_next[45:40]};
            if (crc_en_q && rx_crc != rx_next[7:1]) crc_err_d = 1'b1;
          end
        end
      end
      S_GAP: if (fall) begin
        if (cnt_q == 16'd7) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          sd_clk_d = 1'b0;
          div_d    = '0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase

    irq_d = done_d & ie_d;

    rdata_d = '0;
    case (address)
      3'd0: rdata_d = arg_q;
      3'd1: rdata_d = {21'b0, crc_en_q, rtype_q, 2'b0, idx_q};
      3'd2: rdata_d = {27'b0, ie_q, crc_err_q, tout_q, done_q, busy};
      3'd3: rdata_d = resp_q[0];
      3'd4: rdata_d = resp_q[1];
      3'd5: rdata_d = resp_q[2];
      3'd6: rdata_d = resp_q[3];
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE; div_q   <= '0;   sd_clk_q <= 1'b0;
      cnt_q     <= '0;     tx_q    <= '0;   rx_q     <= '0;
      oe_q      <= 1'b0;   out_q   <= 1'b1; arg_q    <= '0;
      idx_q     <= '0;     rtype_q <= '0;   crc_en_q <= 1'b0;
      resp_q    <= '0;     done_q  <= 1'b0; tout_q   <= 1'b0;
      crc_err_q <= 1'b0;   ie_q    <= 1'b0; irq_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;   div_q   <= div_d;   sd_clk_q <= sd_clk_d;
      cnt_q     <= cnt_d;     tx_q    <= tx_d;    rx_q     <= rx_d;
      oe_q      <= oe_d;      out_q   <= out_d;   arg_q    <= arg_d;
      idx_q     <= idx_d;     rtype_q <= rtype_d; crc_en_q <= crc_en_d;
      resp_q    <= resp_d;    done_q  <= done_d;  tout_q   <= tout_d;
      crc_err_q <= crc_err_d; ie_q    <= ie_d;    irq_q    <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign sd_cmd   = oe_q ? out_q : 1'bz;
  assign sd_clk   = sd_clk_q;
  assign irq      = irq_q;
  assign readdata = rdata_q;
endmodule

// File: tb/tb_sd_cmd_engine.sv
// Bench for sd_cmd_engine: bus-driven commands, a card model on the CMD line and a
// scoreboard of expected frames, timings, status and response registers.
module tb_sd_cmd_engine;
  logic        clk = 1'b0, reset = 1'b1;
  logic [2:0]  address = 3'd2;
  logic        chipselect = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        sd_clk, irq;
  wire         sd_cmd;
  logic        card_oe = 1'b0, card_bit = 1'b1;
  int          ncmp = 0, nerr = 0, cyc = 0;

  typedef struct { string name; logic [135:0] val; } exp_t;
  exp_t sb[$];

  pullup (sd_cmd);
  assign sd_cmd = card_oe ? card_bit : 1'bz;

  sd_cmd_engine #(.CLK_DIV(4), .RESP_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .sd_clk(sd_clk), .sd_cmd(sd_cmd), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CRC7 by polynomial long division (x^7+x^3+1), zero initial remainder
  function automatic logic [6:0] tb_crc7(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] frame_of(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, tb_crc7({2'b01, idx, arg}), 1'b1};
  endfunction

  task automatic sb_push(input string n, input logic [135:0] v);
    exp_t e;
    e.name = n; e.val = v;
    sb.push_back(e);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = 3'd2;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk); address = a;
    @(negedge clk); d = readdata;
    address = 3'd2;
  endtask

  task automatic wait_edge(input logic lvl, output int t);
    logic prev;
    prev = sd_clk;
    t = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sd_clk === lvl && prev !== lvl) begin t = cyc; return; end
      prev = sd_clk;
    end
    ncmp++; nerr++;
    $display("FAIL sd_clk_edge: no edge to %0d within 64 clk (got none, required one)", lvl);
  endtask

  task automatic run_cmd(input logic [31:0] arg, input logic [31:0] cmdw, input int rlen,
                         input logic [135:0] rbits, input bit inject,
                         output logic [47:0] frame, output int first_fall, output int busy_clks,
                         output logic [31:0] status, output logic [3:0][31:0] resp,
                         output logic irq_o);
    int c0, t;
    bus_write(3'd0, arg);
    bus_write(3'd1, cmdw);
    c0 = cyc;
    wait_edge(1'b0, t);
    first_fall = t - c0;
    if (inject) bus_write(3'd1, 32'h0000_0605);
    frame = '0;
    for (int i = 0; i < 48; i++) begin
      wait_edge(1'b1, t);
      frame = {frame[46:0], sd_cmd};
    end
    if (rlen != 0) begin
      wait_edge(1'b0, t);
      for (int i = rlen - 1; i >= 0; i--) begin
        wait_edge(1'b0, t);
        card_oe = 1'b1; card_bit = rbits[i];
      end
      wait_edge(1'b0, t);
      card_oe = 1'b0;
    end
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (readdata[0] === 1'b0) break;
    end
    busy_clks = cyc - c0 - 1;
    irq_o = irq;
    bus_read(3'd2, status);
    for (int k = 0; k < 4; k++) bus_read(3'(3 + k), resp[k]);
  endtask

  task automatic test_reset;
    logic [135:0] got[$]; exp_t e; logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    sb_push("rst_readdata", 136'(0)); sb_push("rst_sd_clk", 136'(0));
    sb_push("rst_irq", 136'(0));      sb_push("rst_sd_cmd_released", 136'(1));
    got.push_back(136'(readdata)); got.push_back(136'(sd_clk));
    got.push_back(136'(irq));      got.push_back(136'(sd_cmd));
    reset = 1'b0;
    sb_push("rst_status", 136'(0)); sb_push("arg_rw", 136'(32'hA5A5_5A5A)); sb_push("addr7", 136'(0));
    bus_read(3'd2, d); got.push_back(136'(d));
    bus_write(3'd0, 32'hA5A5_5A5A);
    bus_read(3'd0, d); got.push_back(136'(d));
    bus_read(3'd7, d); got.push_back(136'(d));
    foreach (got[i]) begin
      e = sb.pop_front(); ncmp++;
      if (got[i] !== e.val) begin nerr++; $display("FAIL %s: got %h required %h", e.name, got[i], e.val); end
    end
  endtask

  task automatic test_cmd0;
    logic [135:0] got[$]; exp_t e; logic [47:0] fr; int ff, bc;
    logic [31:0] st; logic [3:0][31:0] rs; logic iq;
    bus_write(3'd2, 32'h10);
    sb_push("cmd0_frame", 136'(48'h40_0000_0000_95)); sb_push("cmd0_first_fall", 136'(8));
    sb_push("cmd0_busy_clks", 136'(456));               sb_push("cmd0_status", 136'(32'h12));
    sb_push("cmd0_irq", 136'(1));                       sb_push("cmd0_status_clr", 136'(32'h10));
    sb_push("cmd0_irq_clr", 136'(0));
    run_cmd(32'h0, 32'h0, 0, '0, 1'b0, fr, ff, bc, st, rs, iq);
    got.push_back(136'(fr)); got.push_back(136'(ff));
    got.push_back(136'((bc >= 448 && bc <= 464) ? 456 : bc));
    got.push_back(136'(st)); got.push_back(136'(iq));
    bus_write(3'd2, 32'h12);
    bus_read(3'd2, st); got.push_back(136'(st)); got.push_back(136'(irq));
    foreach (got[i]) begin
      e = sb.pop_front(); ncmp++;
      if (got[i] !== e.val) begin nerr++; $display("FAIL %s: got %h required %h", e.name, got[i], e.val); end
    end
  endtask

  task automatic test_cmd8(input bit flip);
    logic [135:0] got[$]; exp_t e; logic [47:0] fr; int ff, bc;
    logic [31:0] st; logic [3:0][31:0] rs; logic iq; logic [135:0] rb; logic [6:0] c;
    c  = tb_crc7({8'h08, 32'h0000_01AA});
    rb = 136'({8'h08, 32'h0000_01AA, c, 1'b1});
    if (flip) rb[28] = ~rb[28];
    sb_push("cmd8_frame", 136'(48'h48_0000_01AA_87));
    sb_push("cmd8_resp0", 136'(flip ? 32'h0010_01AA : 32'h0000_01AA));
    sb_push("cmd8_resp1", 136'({17'b0, c, 2'b0, 6'd8}));
    sb_push("cmd8_status", 136'(flip ? 32'h1A : 32'h12));
    run_cmd(32'h0000_01AA, 32'h0000_0508, 48, rb, 1'b0, fr, ff, bc, st, rs, iq);
    got.push_back(136'(fr)); got.push_back(136'(rs[0]));
    got.push_back(136'(rs[1])); got.push_back(136'(st));
    foreach (got[i]) begin
      e = sb.pop_front(); ncmp++;
      if (got[i] !== e.val) begin nerr++; $display("FAIL %s: got %h required %h", e.name, got[i], e.val); end
    end
  endtask

  task automatic test_r2;
    logic [135:0] got[$]; exp_t e; logic [47:0] fr; int ff, bc;
    logic [31:0] st; logic [3:0][31:0] rs; logic iq; logic [135:0] rb; logic [127:0] pat;
    pat = {$urandom, $urandom, $urandom, $urandom};
    rb  = {8'h3F, pat[127:1], 1'b1};
    sb_push("r2_frame", 136'(frame_of(6'd2, 32'h0)));
    sb_push("r2_resp", 136'(rb[127:0]));
    sb_push("r2_status", 136'(32'h12));
    run_cmd(32'h0, 32'h0000_0602, 136, rb, 1'b0, fr, ff, bc, st, rs, iq);
    got.push_back(136'(fr)); got.push_back(136'(rs)); got.push_back(136'(st));
    foreach (got[i]) begin
      e = sb.pop_front(); ncmp++;
      if (got[i] !== e.val) begin nerr++; $display("FAIL %s: got %h required %h", e.name, got[i], e.val); end
    end
  endtask

  task automatic test_timeout;
    logic [135:0] got[$]; exp_t e; logic [47:0] fr; int ff, bc;
    logic [31:0] st; logic [3:0][31:0] rs; logic iq;
    sb_push("to_frame", 136'(frame_of(6'd55, 32'h1234_0000)));
    sb_push("to_status", 136'(32'h16));
    sb_push("to_resp_cleared", 136'(0));
    sb_push("to_busy_clks", 136'(960));
    run_cmd(32'h1234_0000, 32'h0000_0137, 0, '0, 1'b0, fr, ff, bc, st, rs, iq);
    got.push_back(136'(fr)); got.push_back(136'(st)); got.push_back(136'(rs));
    got.push_back(136'((bc >= 952 && bc <= 968) ? 960 : bc));
    foreach (got[i]) begin
      e = sb.pop_front(); ncmp++;
      if (got[i] !== e.val) begin nerr++; $display("FAIL %s: got %h required %h", e.name, got[i], e.val); end
    end
  endtask

  task automatic test_back_to_back;
    logic [135:0] got[$]; exp_t e; logic [47:0] fr; int ff, bc;
    logic [31:0] st; logic [3:0][31:0] rs; logic iq;
    sb_push("b2b_frame", 136'(frame_of(6'd17, 32'hDEAD_BEEF)));
    sb_push("b2b_busy_clks", 136'(456));
    sb_push("b2b_status", 136'(32'h12));
    run_cmd(32'hDEAD_BEEF, 32'h0000_0011, 0, '0, 1'b1, fr, ff, bc, st, rs, iq);
    got.push_back(136'(fr));
    got.push_back(136'((bc >= 448 && bc <= 464) ? 456 : bc));
    got.push_back(136'(st));
    foreach (got[i]) begin
      e = sb.pop_front(); ncmp++;
      if (got[i] !== e.val) begin nerr++; $display("FAIL %s: got %h required %h", e.name, got[i], e.val); end
    end
  endtask

  task automatic test_reset_mid_send;
    logic [135:0] got[$]; exp_t e; logic [47:0] fr; int ff, bc, t;
    logic [31:0] st; logic [3:0][31:0] rs; logic iq;
    sb_push("mid_start_bit", 136'(0));      sb_push("mid_sd_cmd_released", 136'(1));
    sb_push("mid_sd_clk", 136'(0));         sb_push("mid_readdata", 136'(0));
    sb_push("mid_irq", 136'(0));
    sb_push("post_frame", 136'(48'h40_0000_0000_95));
    sb_push("post_busy_clks", 136'(456));   sb_push("post_status", 136'(32'h02));
    sb_push("post_irq", 136'(0));
    bus_write(3'd0, 32'h1234_5678);
    bus_write(3'd1, 32'h0000_0011);
    wait_edge(1'b0, t);
    got.push_back(136'(sd_cmd));
    @(negedge clk);
    reset = 1'b1;
    #1;
    got.push_back(136'(sd_cmd)); got.push_back(136'(sd_clk));
    got.push_back(136'(readdata)); got.push_back(136'(irq));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_cmd(32'h0, 32'h0, 0, '0, 1'b0, fr, ff, bc, st, rs, iq);
    got.push_back(136'(fr));
    got.push_back(136'((bc >= 448 && bc <= 464) ? 456 : bc));
    got.push_back(136'(st)); got.push_back(136'(iq));
    foreach (got[i]) begin
      e = sb.pop_front(); ncmp++;
      if (got[i] !== e.val) begin nerr++; $display("FAIL %s: got %h required %h", e.name, got[i], e.val); end
    end
  endtask

  initial begin
    test_reset;
    test_cmd0;
    test_cmd8(1'b0);
    test_cmd8(1'b1);
    test_r2;
    test_timeout;
    test_back_to_back;
    test_reset_mid_send;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1);
  end
endmodule
